// File: rtl/sdram_act_seq_if.sv
// rtl/sdram_act_seq_if.sv - host request/strobe bundle between requester and sdram_act_seq
interface sdram_act_seq_if #(
  parameter int ADDR_W = 23
);
  logic              req;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ack;
  logic              busy;
  logic              rd_valid;
  logic              wr_strobe;

  modport master (
    output req, req_wr, req_addr,
    input  req_ack, busy, rd_valid, wr_strobe
  );

  modport slave (
    input  req, req_wr, req_addr,
    output req_ack, busy, rd_valid, wr_strobe
  );
endinterface

// File: rtl/sdram_act_seq.sv
// rtl/sdram_act_seq.sv - single-access SDRAM bank sequencer: ACTIVE, tRCD via rcd_cntr, READ/WRITE, PRECHARGE
module sdram_act_seq #(
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int BA_W   = 2,
  parameter int CL     = 2,
  parameter int WR_CYC = 1,
  parameter int RP_CYC = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  sdram_act_seq_if.slave   host,
  input  logic [1:0]       rcd_cfg,
  output logic             ld_rcd,
  output logic [1:0]       rcd_max,
  input  logic             rcd_end,
  output logic             cs_n,
  output logic             ras_n,
  output logic             cas_n,
  output logic             we_n,
  output logic [BA_W-1:0]  ba,
  output logic [ROW_W-1:0] sd_addr
);

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [2:0] CL_M1 = 3'(CL - 1);
  localparam logic [2:0] WR_M1 = 3'(WR_CYC - 1);
  localparam logic [2:0] RP_M1 = 3'(RP_CYC - 1);

  // Clears A10 so neither the column access nor PRECHARGE requests auto/all-bank behaviour.
  localparam logic [ROW_W-1:0] A10_CLR = ~(ROW_W'(1) << 10);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_RCD, S_RW, S_DLY, S_PRE, S_RP
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               lat_wr;
  logic [BA_W-1:0]    lat_bank;
  logic [ROW_W-1:0]   lat_row;
  logic [COL_W-1:0]   lat_col;
  logic [1:0]         lat_rcd;

  logic [3:0]         cmd;
  logic               ack, rdv, wrs;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lat_wr   <= 1'b0;
      lat_bank <= '0;
      lat_row  <= '0;
      lat_col  <= '0;
      lat_rcd  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && host.req) begin
        lat_wr                       <= host.req_wr;
        {lat_bank, lat_row, lat_col} <= host.req_addr;
        lat_rcd                      <= rcd_cfg;
      end
    end
  end

  // Outputs depend only on registered state so no input reaches a pin combinationally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd     = CMD_NOP;
    ba      = '0;
    sd_addr = '0;
    ld_rcd  = 1'b0;
    rcd_max = 2'b00;
    ack     = 1'b0;
    rdv     = 1'b0;
    wrs     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host.req) state_d = S_ACT;
      end
      S_ACT: begin
        cmd     = CMD_ACT;
        ba      = lat_bank;
        sd_addr = lat_row;
        ld_rcd  = 1'b1;
        rcd_max = lat_rcd;
        ack     = 1'b1;
        state_d = S_RCD;
      end
      S_RCD: begin
        if (rcd_end) state_d = S_RW;
      end
      S_RW: begin
        cmd     = lat_wr ? CMD_WR : CMD_RD;
        ba      = lat_bank;
        sd_addr = ROW_W'(lat_col) & A10_CLR;
        wrs     = lat_wr;
        cnt_d   = lat_wr ? WR_M1 : CL_M1;
        state_d = S_DLY;
      end
      S_DLY: begin
        if (cnt_q == 3'd0) begin
          rdv     = ~lat_wr;
          state_d = S_PRE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_PRE: begin
        cmd     = CMD_PRE;
        ba      = lat_bank;
        sd_addr = '0;
        cnt_d   = RP_M1;
        state_d = S_RP;
      end
      S_RP: begin
        if (cnt_q == 3'd0) state_d = S_IDLE;
        else cnt_d = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd;
  assign host.req_ack   = ack;
  assign host.busy      = (state_q != S_IDLE);
  assign host.rd_valid  = rdv;
  assign host.wr_strobe = wrs;

endmodule

// File: tb/tb_sdram_act_seq.sv
// tb/tb_sdram_act_seq.sv - self-checking bench for sdram_act_seq against a timeline model
module tb_sdram_act_seq;

  localparam int NC = 1024;
  localparam logic [3:0] NOP = 4'b1111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100, PRE = 4'b0010;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req = 1'b0, req_wr = 1'b0;
  logic [22:0] req_addr = '0;
  logic [1:0]  rcd_cfg = 2'd0;
  logic        force_low = 1'b0;

  int n_chk = 0, n_err = 0, cyc = 0;

  always #5 Clk = ~Clk;

  sdram_act_seq_if #(.ADDR_W(23)) host0 ();
  sdram_act_seq_if #(.ADDR_W(23)) host1 ();
  assign host0.req = req;  assign host0.req_wr = req_wr;  assign host0.req_addr = req_addr;
  assign host1.req = req;  assign host1.req_wr = req_wr;  assign host1.req_addr = req_addr;

  logic ld0, ld1, cs0, cs1, ras0, ras1, cas0, cas1, we0, we1;
  logic [1:0]  rmax0, rmax1, ba0, ba1;
  logic [11:0] a0, a1;
  logic [1:0]  rcnt0 = 2'd0, rcnt1 = 2'd0;
  logic        rcd_end0, rcd_end1;

  // External tRCD counters as the real rcd_cntr behaves: load on pulse, count to 0, idle high.
  always @(posedge Clk) begin
    if (ld0) rcnt0 <= rmax0; else if (rcnt0 != 0) rcnt0 <= rcnt0 - 2'd1;
    if (ld1) rcnt1 <= rmax1; else if (rcnt1 != 0) rcnt1 <= rcnt1 - 2'd1;
  end
  assign rcd_end0 = force_low ? 1'b0 : (rcnt0 == 2'd0);
  assign rcd_end1 = force_low ? 1'b0 : (rcnt1 == 2'd0);

  sdram_act_seq #(.ROW_W(12), .COL_W(9), .BA_W(2), .CL(2), .WR_CYC(1), .RP_CYC(2)) dut0 (
    .Clk(Clk), .Reset(Reset), .host(host0), .rcd_cfg(rcd_cfg), .ld_rcd(ld0), .rcd_max(rmax0),
    .rcd_end(rcd_end0), .cs_n(cs0), .ras_n(ras0), .cas_n(cas0), .we_n(we0), .ba(ba0), .sd_addr(a0));

  sdram_act_seq #(.ROW_W(12), .COL_W(9), .BA_W(2), .CL(3), .WR_CYC(3), .RP_CYC(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .host(host1), .rcd_cfg(rcd_cfg), .ld_rcd(ld1), .rcd_max(rmax1),
    .rcd_end(rcd_end1), .cs_n(cs1), .ras_n(ras1), .cas_n(cas1), .we_n(we1), .ba(ba1), .sd_addr(a1));

  // {ack, busy, rd_valid, wr_strobe, ld_rcd, rcd_max[1:0], cmd[3:0], ba[1:0], sd_addr[11:0]}
  logic [24:0] act0, act1;
  assign act0 = {host0.req_ack, host0.busy, host0.rd_valid, host0.wr_strobe, ld0, rmax0, cs0, ras0, cas0, we0, ba0, a0};
  assign act1 = {host1.req_ack, host1.busy, host1.rd_valid, host1.wr_strobe, ld1, rmax1, cs1, ras1, cas1, we1, ba1, a1};

  logic [24:0] expv [2][NC];
  logic [24:0] actv [2][NC];
  int  p_cl [2] = '{2, 3};
  int  p_wr [2] = '{1, 3};
  int  p_rp [2] = '{2, 1};
  int  free_at [2] = '{0, 0};
  int  wait_from [2] = '{0, 0};
  bit  waiting [2] = '{1'b0, 1'b0};
  bit  m_wr [2];
  logic [22:0] m_addr [2];

  function automatic logic [24:0] mk(logic ack, logic bsy, logic rdv, logic wrs, logic ld,
                                     logic [1:0] rm, logic [3:0] cmd, logic [1:0] b, logic [11:0] a);
    return {ack, bsy, rdv, wrs, ld, rm, cmd, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic put(input int d, input int k, input logic [24:0] v);
    if (k < NC) expv[d][k] = v;
  endtask

  // Once tRCD has elapsed the rest of the access is fixed: lay it out by cycle arithmetic.
  task automatic sched_rw(input int d, input int r);
    int len, p;
    logic [1:0] b;
    b   = m_addr[d][22:21];
    len = m_wr[d] ? p_wr[d] : p_cl[d];
    put(d, r, mk(0, 1, 0, m_wr[d], 0, 2'd0, m_wr[d] ? WR : RD, b, {3'b000, m_addr[d][8:0]}));
    for (int i = 1; i <= len; i++) put(d, r + i, mk(0, 1, (!m_wr[d] && i == len), 0, 0, 2'd0, NOP, 2'd0, 12'd0));
    p = r + len + 1;
    put(d, p, mk(0, 1, 0, 0, 0, 2'd0, PRE, b, 12'd0));
    for (int i = 1; i <= p_rp[d]; i++) put(d, p + i, mk(0, 1, 0, 0, 0, 2'd0, NOP, 2'd0, 12'd0));
    free_at[d] = p + p_rp[d] + 1;
  endtask

  task automatic model_step(input int d, input int c, input logic rend);
    if (Reset) begin
      for (int k = c + 1; k < NC; k++) expv[d][k] = mk(0, 0, 0, 0, 0, 2'd0, NOP, 2'd0, 12'd0);
      free_at[d] = c + 1;
      waiting[d] = 1'b0;
    end else if (waiting[d] && c >= wait_from[d]) begin
      if (rend) begin
        waiting[d] = 1'b0;
        sched_rw(d, c + 1);
      end else begin
        put(d, c + 1, mk(0, 1, 0, 0, 0, 2'd0, NOP, 2'd0, 12'd0));
      end
    end else if (!waiting[d] && c >= free_at[d] && req) begin
      m_wr[d]   = req_wr;
      m_addr[d] = req_addr;
      put(d, c + 1, mk(1, 1, 0, 0, 1, rcd_cfg, ACT, req_addr[22:21], req_addr[20:9]));
      put(d, c + 2, mk(0, 1, 0, 0, 0, 2'd0, NOP, 2'd0, 12'd0));
      waiting[d]   = 1'b1;
      wait_from[d] = c + 2;
      free_at[d]   = NC * 2;
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    if (cyc >= 1 && cyc < NC) begin
      chk("dut0_vec", 32'(act0), 32'(expv[0][cyc]));
      chk("dut1_vec", 32'(act1), 32'(expv[1][cyc]));
    end
    if (cyc < NC) begin
      actv[0][cyc] = act0;
      actv[1][cyc] = act1;
    end
    model_step(0, cyc, rcd_end0);
    model_step(1, cyc, rcd_end1);
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  function automatic int find_cmd(int d, int from, logic [3:0] cmd);
    for (int c = from; c < from + 40 && c < NC; c++) if (actv[d][c][17:14] == cmd) return c;
    return -1;
  endfunction

  function automatic int find_bit(int d, int from, int b, logic v);
    for (int c = from; c < from + 40 && c < NC; c++) if (actv[d][c][b] == v) return c;
    return -1;
  endfunction

  function automatic int count_bit(int d, int from, int len, int b, logic v);
    int n = 0;
    for (int c = from; c < from + len && c < NC; c++) if (actv[d][c][b] == v) n++;
    return n;
  endfunction

  int c0, cr;
  bit prev_req;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NC; k++) begin
        expv[d][k] = mk(0, 0, 0, 0, 0, 2'd0, NOP, 2'd0, 12'd0);
        actv[d][k] = '0;
      end
    tick(); tick();
    Reset = 1'b0;
    tick();

    // Read, rcd_cfg=2
    c0 = cyc; req = 1; req_wr = 0; req_addr = 23'($urandom); rcd_cfg = 2'd2;
    tick(); tick(); req = 0;
    repeat (16) tick();
    chk("s1_act", 32'(find_cmd(0, c0, ACT) - c0), 32'd1);
    chk("s1_read", 32'(find_cmd(0, c0, RD) - c0), 32'd5);
    chk("s1_rdv", 32'(find_bit(0, c0, 22, 1'b1) - c0), 32'd7);
    chk("s1_pre", 32'(find_cmd(0, c0, PRE) - c0), 32'd8);
    chk("s1_idle", 32'(find_bit(0, c0 + 2, 23, 1'b0) - c0), 32'd11);
    chk("s1_row", 32'(actv[0][c0 + 1][13:0]), 32'({req_addr[22:21], req_addr[20:9]}));
    chk("s1_col", 32'(actv[0][c0 + 5][13:0]), 32'({req_addr[22:21], 3'b000, req_addr[8:0]}));

    // Write, rcd_cfg=0
    c0 = cyc; req = 1; req_wr = 1; req_addr = 23'($urandom); rcd_cfg = 2'd0;
    tick(); req = 0;
    repeat (16) tick();
    chk("s2_act", 32'(find_cmd(0, c0, ACT) - c0), 32'd1);
    chk("s2_write", 32'(find_cmd(0, c0, WR) - c0), 32'd3);
    chk("s2_wstb", 32'(find_bit(0, c0, 21, 1'b1) - c0), 32'd3);
    chk("s2_pre", 32'(find_cmd(0, c0, PRE) - c0), 32'd5);
    chk("s2_we_lo", 32'(count_bit(0, c0, 16, 14, 1'b0)), 32'd2);

    // Read, rcd_cfg=3 on the CL=3 build
    c0 = cyc; req = 1; req_wr = 0; req_addr = 23'($urandom); rcd_cfg = 2'd3;
    tick(); req = 0;
    repeat (16) tick();
    chk("s3_read", 32'(find_cmd(1, c0, RD) - c0), 32'd6);
    chk("s3_rdv", 32'(find_bit(1, c0, 22, 1'b1) - c0), 32'd9);
    chk("s3_rdv_n", 32'(count_bit(1, c0, 16, 22, 1'b1)), 32'd1);
    chk("s3_pre", 32'(find_cmd(1, c0, PRE) - c0), 32'd10);

    // rcd_end held low for 20 cycles after ACTIVE
    c0 = cyc; req = 1; req_wr = 0; req_addr = 23'($urandom); rcd_cfg = 2'd1;
    tick(); req = 0; force_low = 1;
    repeat (20) tick();
    force_low = 0; cr = cyc;
    repeat (16) tick();
    chk("s4_read", 32'(find_cmd(0, c0, RD) - cr), 32'd1);
    chk("s4_busy", 32'(actv[0][cr][23]), 32'd1);

    // req held across two accesses
    c0 = cyc; req = 1; req_wr = 0; rcd_cfg = 2'd1;
    repeat (12) tick();
    req = 0;
    repeat (14) tick();
    chk("s5_acks", 32'(count_bit(0, c0, 26, 24, 1'b1)), 32'd2);
    chk("s5_ack2", 32'(find_bit(0, c0 + 2, 24, 1'b1) - c0), 32'd11);

    // req toggled during RCD
    c0 = cyc; req = 1; rcd_cfg = 2'd3;
    tick(); req = 0; tick();
    req = 1; tick(); req = 0; tick(); req = 1; tick(); req = 0; tick();
    repeat (14) tick();
    chk("s5_tog", 32'(count_bit(0, c0, 20, 24, 1'b1)), 32'd1);

    // Reset in DLY of a read
    c0 = cyc; req = 1; req_wr = 0; rcd_cfg = 2'd0;
    tick(); req = 0;
    repeat (3) tick();
    Reset = 1; tick(); Reset = 0;
    repeat (10) tick();
    chk("s6_rdv", 32'(count_bit(0, c0, 15, 22, 1'b1)), 32'd0);
    chk("s6_pre", 32'(find_cmd(0, c0, PRE)), 32'hFFFF_FFFF);
    chk("s6_busy", 32'(actv[0][c0 + 5][23]), 32'd0);
    c0 = cyc; req = 1;
    tick(); req = 0;
    repeat (14) tick();
    chk("s6_act", 32'(find_cmd(0, c0, ACT) - c0), 32'd1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      prev_req  = req;
      req       = ($urandom_range(0, 3) != 0);
      req_wr    = 1'($urandom);
      req_addr  = 23'($urandom);
      if (!prev_req) rcd_cfg = 2'($urandom_range(0, 3));
      force_low = ($urandom_range(0, 9) == 0);
      Reset     = ($urandom_range(0, 99) == 0);
      tick();
    end
    req = 0; Reset = 0; force_low = 0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
